// File: rtl/xy_path_sequencer_if.sv
// ---------------------------------------------------------------------------
// xy_path_sequencer_if
// Bundles the waypoint-write, run-control, position-feedback, target and
// status signals of the XY path sequencer.
//   master : the controller / positioner side (drives writes, controls, pos)
//   slave  : the sequencer side (drives targets, motion request, status)
// Parameter DEPTH must match the DEPTH of the connected sequencer.
// ---------------------------------------------------------------------------
interface xy_path_sequencer_if #(
   parameter int DEPTH = 8
);
   localparam int IDX_W = $clog2(DEPTH);

   // waypoint write (BCD digits)
   logic             wr_en;
   logic [3:0]       wr_x;
   logic [3:0]       wr_y;
   // run control
   logic             start;
   logic             abort;
   logic             clear;
   // position feedback from the positioner (BCD)
   logic [3:0]       x_pos;
   logic [3:0]       y_pos;
   // target presented to the positioner (BCD)
   logic [3:0]       x_target;
   logic [3:0]       y_target;
   logic             motion;
   // status
   logic             busy;
   logic             done;
   logic [IDX_W-1:0] wp_idx;
   logic [IDX_W:0]   wp_count;
   logic             overflow;
   logic             bcd_err;
   logic             timeout;

   modport master (
      output wr_en, wr_x, wr_y, start, abort, clear, x_pos, y_pos,
      input  x_target, y_target, motion, busy, done, wp_idx, wp_count,
             overflow, bcd_err, timeout
   );

   modport slave (
      input  wr_en, wr_x, wr_y, start, abort, clear, x_pos, y_pos,
      output x_target, y_target, motion, busy, done, wp_idx, wp_count,
             overflow, bcd_err, timeout
   );
endinterface

// File: rtl/xy_path_sequencer.sv
// ---------------------------------------------------------------------------
// xy_path_sequencer
// Stores up to DEPTH BCD (X,Y) waypoints and, on start, presents them one at
// a time to an XY positioner: each waypoint is issued with a motion request,
// held until the fed-back position matches, then motion is dropped for
// SETTLE_CYC cycles before the next waypoint. A one-cycle done pulse ends
// the path.
//
// Ports:
//   clk    : single clock, all state changes on the rising edge
//   reset  : synchronous, active-high reset
//   bus    : xy_path_sequencer_if.slave
//            in : wr_en/wr_x/wr_y, start, abort, clear, x_pos/y_pos
//            out: x_target/y_target, motion, busy, done, wp_idx, wp_count,
//                 overflow, bcd_err, timeout
//
// Configuration:
//   TIMEOUT_EN (macro) : when defined, an 8-bit MOVE watchdog sends the FSM
//                        to FAULT after 255 MOVE cycles without arrival and
//                        sets the sticky timeout flag. When undefined, MOVE
//                        waits indefinitely and timeout is tied low.
// ---------------------------------------------------------------------------
module xy_path_sequencer #(
   parameter int DEPTH      = 8,
   parameter int SETTLE_CYC = 2
) (
   input  logic               clk,
   input  logic               reset,
   xy_path_sequencer_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_MOVE,
      S_SETTLE,
`ifdef TIMEOUT_EN
      S_DONE,
      S_FAULT
`else
      S_DONE
`endif
   } state_t;

   state_t           r_state;
   logic [3:0]       r_buf_x [DEPTH];
   logic [3:0]       r_buf_y [DEPTH];
   logic [3:0]       r_x_target;
   logic [3:0]       r_y_target;
   logic             r_motion;
   logic             r_busy;
   logic             r_done;
   logic [IDX_W-1:0] r_wp_idx;
   logic [CNT_W-1:0] r_wp_count;
   logic             r_overflow;
   logic             r_bcd_err;
   logic [3:0]       r_settle_cnt;
`ifdef TIMEOUT_EN
   logic [7:0]       r_wdog;
   logic             r_timeout;
`endif

   logic             w_bcd_ok;
   logic             w_full;
   logic             w_append;
   logic             w_arrive;
   logic             w_last;
   logic [IDX_W-1:0] w_next_idx;

   assign w_bcd_ok   = (bus.wr_x <= 4'd9) && (bus.wr_y <= 4'd9);
   assign w_full     = (r_wp_count == CNT_W'(DEPTH));
   // clear takes precedence over a write presented in the same cycle
   assign w_append   = (r_state == S_IDLE) && bus.wr_en && !bus.clear
                       && w_bcd_ok && !w_full;
   assign w_arrive   = (bus.x_pos == r_x_target) && (bus.y_pos == r_y_target);
   assign w_last     = ({1'b0, r_wp_idx} == (r_wp_count - CNT_W'(1)));
   assign w_next_idx = r_wp_idx + IDX_W'(1);

   // NOTE: the waypoint RAM has no reset; its contents are only meaningful
   // below wp_count, which is reset, so clearing it would only cost logic.
   always_ff @(posedge clk) begin
      if (w_append) begin
         r_buf_x[r_wp_count[IDX_W-1:0]] <= bus.wr_x;
         r_buf_y[r_wp_count[IDX_W-1:0]] <= bus.wr_y;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_x_target   <= 4'd0;
         r_y_target   <= 4'd0;
         r_motion     <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_wp_idx     <= '0;
         r_wp_count   <= '0;
         r_overflow   <= 1'b0;
         r_bcd_err    <= 1'b0;
         r_settle_cnt <= 4'd0;
`ifdef TIMEOUT_EN
         r_wdog       <= 8'd0;
         r_timeout    <= 1'b0;
`endif
      end else begin
         // NOTE: done defaults low every cycle and is only raised on the
         // SETTLE->DONE transition, which makes it a single-cycle pulse;
         // a later non-blocking assignment in this block overrides it.
         r_done <= 1'b0;

         if ((r_state != S_IDLE) && bus.abort) begin
            // abort wins over start, arrival and every other transition
            r_state  <= S_IDLE;
            r_motion <= 1'b0;
            r_busy   <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.clear) begin
                     r_wp_count <= '0;
                     r_overflow <= 1'b0;
                     r_bcd_err  <= 1'b0;
`ifdef TIMEOUT_EN
                     r_timeout  <= 1'b0;
`endif
                  end else begin
                     if (bus.wr_en) begin
                        if (w_full)    r_overflow <= 1'b1;
                        if (!w_bcd_ok) r_bcd_err  <= 1'b1;
                        if (w_append)  r_wp_count <= r_wp_count + CNT_W'(1);
                     end
                     if (bus.start && (r_wp_count != '0)) begin
                        // target and motion are loaded on entry so they are
                        // already valid during the ISSUE cycle
                        r_state    <= S_ISSUE;
                        r_busy     <= 1'b1;
                        r_wp_idx   <= '0;
                        r_x_target <= r_buf_x[0];
                        r_y_target <= r_buf_y[0];
                        r_motion   <= 1'b1;
                     end
                  end
               end

               S_ISSUE: begin
                  r_state <= S_MOVE;
`ifdef TIMEOUT_EN
                  r_wdog  <= 8'd0;
`endif
               end

               S_MOVE: begin
                  if (w_arrive) begin
                     r_state      <= S_SETTLE;
                     r_motion     <= 1'b0;
                     r_settle_cnt <= 4'd0;
`ifdef TIMEOUT_EN
                  end else if (r_wdog == 8'd254) begin
                     // this is the 255th MOVE cycle without arrival
                     r_wdog    <= 8'd255;
                     r_state   <= S_FAULT;
                     r_motion  <= 1'b0;
                     r_timeout <= 1'b1;
                  end else begin
                     r_wdog <= r_wdog + 8'd1;
`endif
                  end
               end

               S_SETTLE: begin
                  if (r_settle_cnt == 4'(SETTLE_CYC - 1)) begin
                     if (w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state    <= S_ISSUE;
                        r_wp_idx   <= w_next_idx;
                        r_x_target <= r_buf_x[w_next_idx];
                        r_y_target <= r_buf_y[w_next_idx];
                        r_motion   <= 1'b1;
                     end
                  end else begin
                     r_settle_cnt <= r_settle_cnt + 4'd1;
                  end
               end

               S_DONE: begin
                  // targets keep the last waypoint; buffer and count retained
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end

`ifdef TIMEOUT_EN
               S_FAULT: begin
                  // held here with busy high until abort or reset
                  r_state <= S_FAULT;
               end
`endif

               default: begin
                  r_state  <= S_IDLE;
                  r_motion <= 1'b0;
                  r_busy   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.x_target = r_x_target;
   assign bus.y_target = r_y_target;
   assign bus.motion   = r_motion;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.wp_idx   = r_wp_idx;
   assign bus.wp_count = r_wp_count;
   assign bus.overflow = r_overflow;
   assign bus.bcd_err  = r_bcd_err;
`ifdef TIMEOUT_EN
   assign bus.timeout  = r_timeout;
`else
   assign bus.timeout  = 1'b0;
`endif

endmodule

// File: doc/xy_path_sequencer.md
XY_PATH_SEQUENCER -- requirements
Module: xy_path_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, 8, waypoint buffer entries (power of 2, 2..16).
REQ-002 SHALL have parameter SETTLE_CYC, 2, cycles motion is held low after arrival before the next waypoint (1..15).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports wr_en in 1, wr_x in 4, wr_y in 4: waypoint write (BCD X/Y).
REQ-006 SHALL have ports start in 1 (run path), abort in 1 (stop run), clear in 1 (empty buffer, clear sticky flags).
REQ-007 SHALL have ports x_pos in 4, y_pos in 4: current BCD position fed back from the positioner.
REQ-008 SHALL have ports x_target out 4, y_target out 4: BCD target presented to the positioner.
REQ-009 SHALL have port motion out 1: positioner motion request, registered.
REQ-010 SHALL have status outputs busy 1, done 1, wp_idx clog2(DEPTH), wp_count clog2(DEPTH)+1, overflow 1, bcd_err 1, timeout 1.

Function
REQ-011 States SHALL be IDLE, ISSUE, MOVE, SETTLE, DONE, plus FAULT when TIMEOUT_EN is defined.
REQ-012 wr_en in IDLE with both digits <=9 and wp_count<DEPTH SHALL append the entry and increment wp_count next cycle.
REQ-013 wr_en with wp_count==DEPTH SHALL be dropped and set sticky overflow; wr_en with any digit >9 SHALL be dropped and set sticky bcd_err.
REQ-014 wr_en outside IDLE SHALL be ignored, no flag change.
REQ-015 clear in IDLE SHALL zero wp_count, overflow, bcd_err, timeout next cycle; clear outside IDLE ignored; clear with wr_en same cycle: clear wins.
REQ-016 IDLE: start with wp_count>0 SHALL go to ISSUE, wp_idx=0; start with wp_count==0 ignored.
REQ-017 ISSUE (1 cycle): x_target/y_target SHALL load buffer[wp_idx], motion=1; then MOVE.
REQ-018 MOVE: motion SHALL stay 1; when x_pos==x_target and y_pos==y_target, go to SETTLE with motion=0 next cycle.
REQ-019 SETTLE: motion=0 for exactly SETTLE_CYC cycles; then if wp_idx==wp_count-1 go to DONE, else wp_idx+1 and ISSUE.
REQ-020 DONE: done SHALL pulse high exactly one cycle, then IDLE; buffer contents and wp_count retained; x_target/y_target hold last waypoint.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 abort in any non-IDLE state SHALL force IDLE, motion=0 next cycle, no done pulse; abort has priority over start and arrival.
REQ-023 start while not IDLE SHALL be ignored.
REQ-024 Duplicate consecutive waypoints SHALL each pass ISSUE, MOVE (arrival same cycle), SETTLE.

Reset
REQ-025 reset SHALL force IDLE; motion=0, busy=0, done=0, x_target=y_target=0, wp_idx=0, wp_count=0, overflow=bcd_err=timeout=0, watchdog=0.
REQ-026 reset SHALL override every other input including mid-run; buffer RAM contents need not be cleared.

Configuration
REQ-027 With TIMEOUT_EN defined: an 8-bit watchdog SHALL clear on entering MOVE and count each MOVE cycle; reaching 255 without arrival SHALL go to FAULT, motion=0, timeout=1 sticky.
REQ-028 FAULT SHALL keep busy=1 and exit to IDLE only on abort or reset.
REQ-029 Without TIMEOUT_EN: no watchdog or FAULT state; MOVE waits indefinitely; timeout output tied 0.

Verification
REQ-030 Write (3,4),(7,1),(0,9); start; model tracks target one step/cycle -> three ISSUE/MOVE/SETTLE passes, wp_idx 0,1,2, one done pulse, busy falls with done.
REQ-031 Write 9 entries with DEPTH=8 -> wp_count=8, overflow=1; clear -> wp_count=0, overflow=0.
REQ-032 Write (A,2) i.e. wr_x=10 -> dropped, bcd_err=1, wp_count unchanged.
REQ-033 Abort during MOVE of waypoint 1 -> motion=0 and busy=0 next cycle, no done; restart begins at wp_idx=0.
REQ-034 TIMEOUT_EN, position frozen off target -> FAULT after 255 MOVE cycles, timeout=1, motion=0; abort -> IDLE.
REQ-035 Assert reset mid-SETTLE -> all outputs at reset values next cycle, wp_count=0.
